// File: rtl/hdb3_pkg.sv
// hdb3_pkg: shared definitions for the HDB3 transmit scheduler.
//   state_t        - scheduler FSM states (IDLE, SYNC, DATA)
//   BYTE_W         - width of a payload byte
//   *_DEF          - default framing constants used as parameter defaults
package hdb3_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [BYTE_W-1:0] SYNC_WORD_DEF = 8'h1B;
  localparam logic [BYTE_W-1:0] FILL_BYTE_DEF = 8'h00;
  localparam int                ENC_LAT_DEF   = 6;

endpackage

// File: rtl/hdb3_delay_line.sv
// hdb3_delay_line: 1-bit delay of DEPTH clock cycles.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears every stage
//   d     - input bit
//   q     - d delayed by DEPTH cycles
module hdb3_delay_line #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] dly_p;

  // one stage per cycle of delay; dly_p[DEPTH-1] is the oldest sample
  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly_p <= '0;
        else        dly_p <= d;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly_p <= '0;
        else        dly_p <= {dly_p[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = dly_p[DEPTH-1];

endmodule

// File: rtl/hdb3_tx_sched.sv
// hdb3_tx_sched: frames payload bytes as SYNC_WORD + FRAME_LEN bytes and
// serializes them MSB-first, one bit per clock, for the HDB3 encoder.
// Ports:
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_en            - run enable, sampled in IDLE and at frame end
//   i_byte          - payload byte
//   i_byte_valid    - i_byte is valid
//   o_byte_ready    - byte is taken this cycle if valid (combinational)
//   o_data          - serial line bit to the encoder
//   o_sof           - marks the cycle carrying SYNC_WORD bit 7
//   o_sof_enc       - o_sof realigned to the encoder output (ENC_LAT later)
//   o_underrun      - pulse on the first bit of each substituted FILL_BYTE
//   o_frame_cnt     - frames started, wrapping
module hdb3_tx_sched
  import hdb3_pkg::*;
#(
  parameter int                FRAME_LEN = 32,
  parameter logic [BYTE_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter logic [BYTE_W-1:0] FILL_BYTE = FILL_BYTE_DEF,
  parameter logic              IDLE_BIT  = 1'b0,
  parameter int                ENC_LAT   = ENC_LAT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_data,
  output logic              o_sof,
  output logic              o_sof_enc,
  output logic              o_underrun,
  output logic [15:0]       o_frame_cnt
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        byte_cnt;
  logic [BYTE_W-1:0] shreg;     // bits still to send of the current byte

  logic              last_bit;
  logic              frame_end;
  logic [BYTE_W-1:0] load_byte;

  assign last_bit  = (bit_cnt == 3'd7);
  assign frame_end = (state == DATA) && last_bit && (byte_cnt == LAST_BYTE);
  assign load_byte = i_byte_valid ? i_byte : FILL_BYTE;

  // no load on the final bit of a frame: the next byte is the sync word
  assign o_byte_ready = last_bit &&
                        ((state == SYNC) || ((state == DATA) && (byte_cnt != LAST_BYTE)));

  // stage p0: state, counters and registered line outputs.
  // o_data always holds the bit on the line now; shreg holds the rest.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shreg       <= '0;
      o_data      <= IDLE_BIT;
      o_sof       <= 1'b0;
      o_underrun  <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_sof      <= 1'b0;
      o_underrun <= 1'b0;
      if ((state == IDLE) || frame_end) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        if (i_en) begin
          state       <= SYNC;
          o_data      <= SYNC_WORD[7];
          shreg       <= {SYNC_WORD[6:0], 1'b0};
          o_sof       <= 1'b1;
          o_frame_cnt <= o_frame_cnt + 16'd1;
        end else begin
          state  <= IDLE;
          o_data <= IDLE_BIT;
          shreg  <= '0;
        end
      end else if (o_byte_ready) begin
        state      <= DATA;
        bit_cnt    <= '0;
        byte_cnt   <= (state == SYNC) ? 8'd0 : byte_cnt + 8'd1;
        o_data     <= load_byte[7];
        shreg      <= {load_byte[6:0], 1'b0};
        o_underrun <= !i_byte_valid;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        o_data  <= shreg[7];
        shreg   <= {shreg[6:0], 1'b0};
      end
    end
  end

  // stage p1..pN: start-of-frame realigned to the encoder output
  hdb3_delay_line #(
    .DEPTH(ENC_LAT)
  ) u_sof_dly (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (o_sof),
    .q     (o_sof_enc)
  );

endmodule

// File: tb/tb_hdb3_tx_sched.sv
// tb_hdb3_tx_sched: randomized self-checking bench for hdb3_tx_sched.
// The reference model tracks a frame as an array of bytes and a bit
// position within the frame, and derives every output from that.
module tb_hdb3_tx_sched;

  localparam int         FL     = 2;
  localparam int         NB     = FL + 1;
  localparam int         NBITS  = NB * 8;
  localparam int         ENC    = 6;
  localparam logic [7:0] SYNCW  = 8'h1B;
  localparam logic [7:0] FILLB  = 8'h00;
  localparam logic       IDLEB  = 1'b0;

  logic        clk;
  logic        i_rst_n;
  logic        i_en;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        o_data;
  logic        o_sof;
  logic        o_sof_enc;
  logic        o_underrun;
  logic [15:0] o_frame_cnt;

  hdb3_tx_sched #(
    .FRAME_LEN (FL),
    .SYNC_WORD (SYNCW),
    .FILL_BYTE (FILLB),
    .IDLE_BIT  (IDLEB),
    .ENC_LAT   (ENC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_data       (o_data),
    .o_sof        (o_sof),
    .o_sof_enc    (o_sof_enc),
    .o_underrun   (o_underrun),
    .o_frame_cnt  (o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit          m_active;
  int          m_pos;
  logic [7:0]  m_frame [NB];
  logic        e_data, e_sof, e_sof_enc, e_under;
  logic [15:0] e_fc;
  bit          q_sof [$];

  int          n_checks;
  int          n_errors;
  logic [31:0] line_bits;
  int          obs_under;
  int          obs_sof;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_active && (m_pos % 8 == 7) && (m_pos != NBITS - 1);
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_pos     = 0;
    e_data    = IDLEB;
    e_sof     = 1'b0;
    e_under   = 1'b0;
    e_sof_enc = 1'b0;
    e_fc      = '0;
    q_sof.delete();
    for (int i = 0; i < ENC - 1; i++) q_sof.push_back(1'b0);
  endtask

  // advance the model by one clock edge with the given inputs
  task automatic model_step(input logic en, input logic v, input logic [7:0] b);
    logic old_sof;
    bit   rdy;
    old_sof = e_sof;
    rdy     = m_ready();
    if (!m_active || m_pos == NBITS - 1) begin
      e_under = 1'b0;
      if (en) begin
        m_active   = 1'b1;
        m_pos      = 0;
        m_frame[0] = SYNCW;
        e_data     = m_frame[0][7];
        e_sof      = 1'b1;
        e_fc       = e_fc + 16'd1;
      end else begin
        m_active = 1'b0;
        e_data   = IDLEB;
        e_sof    = 1'b0;
      end
    end else begin
      if (rdy) begin
        m_frame[m_pos / 8 + 1] = v ? b : FILLB;
        e_under = !v;
      end else begin
        e_under = 1'b0;
      end
      m_pos++;
      e_sof  = 1'b0;
      e_data = m_frame[m_pos / 8][7 - (m_pos % 8)];
    end
    q_sof.push_back(old_sof);
    e_sof_enc = q_sof.pop_front();
  endtask

  task automatic check_outputs();
    check("data",      32'(o_data),       32'(e_data));
    check("ready",     32'(o_byte_ready), 32'(m_ready()));
    check("sof",       32'(o_sof),        32'(e_sof));
    check("sof_enc",   32'(o_sof_enc),    32'(e_sof_enc));
    check("underrun",  32'(o_underrun),   32'(e_under));
    check("frame_cnt", 32'(o_frame_cnt),  32'(e_fc));
    line_bits = {line_bits[30:0], o_data};
    if (o_underrun === 1'b1) obs_under++;
    if (o_sof === 1'b1)      obs_sof++;
  endtask

  // check current outputs, then apply inputs for the next clock edge
  task automatic cycle(input logic en, input logic v, input logic [7:0] b);
    @(negedge clk);
    check_outputs();
    i_en         = en;
    i_byte_valid = v;
    i_byte       = b;
    model_step(en, v, b);
  endtask

  // asynchronous assert away from the clock edge, release on a falling edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    i_rst_n      = 1'b0;
    i_en         = 1'b0;
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
    #1;
    model_reset();
    check_outputs();
    repeat (3) @(negedge clk);
    check_outputs();
    i_rst_n = 1'b1;
    model_step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    n_checks     = 0;
    n_errors     = 0;
    line_bits    = '0;
    obs_under    = 0;
    obs_sof      = 0;
    i_rst_n      = 1'b0;
    i_en         = 1'b0;
    i_byte       = 8'h00;
    i_byte_valid = 1'b0;
    model_reset();

    // idle after reset
    do_reset();
    repeat (20) cycle(1'b0, 1'b0, 8'h00);

    // back-to-back frames; bytes A5/3C on ready, FF held on other cycles
    for (int i = 0; i < 73; i++) begin
      if (m_ready()) cycle(1'b1, 1'b1, (m_pos / 8 == 0) ? 8'hA5 : 8'h3C);
      else           cycle(1'b1, 1'b1, 8'hFF);
      if (i == 24) check("frame_bits", {8'h00, line_bits[23:0]}, 32'h001BA53C);
    end

    // second payload byte never valid
    for (int i = 0; i < 49; i++) begin
      if (i == 1) obs_under = 0;
      if (m_ready()) cycle(1'b1, (m_pos / 8 == 0), 8'h5A);
      else           cycle(1'b1, 1'b0, 8'h5A);
    end
    check("underrun_pulses", 32'(obs_under), 32'd2);

    // drop enable during payload byte 0
    guard = 0;
    while (!(m_active && m_pos >= 8 && m_pos < 16) && guard < 100) begin
      cycle(1'b1, 1'b1, 8'($urandom));
      guard++;
    end
    check("reach_byte0", 32'(guard < 100), 32'd1);
    obs_sof = 0;
    repeat (40) cycle(1'b0, 1'($urandom), 8'($urandom));
    check("no_sof_after_drop", 32'(obs_sof), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'(($urandom % 16) != 0), 1'($urandom), 8'($urandom));
    end

    // reset at bit 3 of a payload byte
    guard = 0;
    while (!(m_active && m_pos >= 8 && (m_pos % 8) == 3) && guard < 100) begin
      cycle(1'b1, 1'b1, 8'($urandom));
      guard++;
    end
    check("reach_bit3", 32'(guard < 100), 32'd1);
    do_reset();
    repeat (10) cycle(1'b0, 1'($urandom), 8'($urandom));
    repeat (30) cycle(1'b1, 1'($urandom), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
